// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock sequencer: debounced buttons drive the game FSM, which produces
// counter load, per-player one-second tick enables, display select and flag-fall tracking.
module chess_clock_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int LOCKOUT  = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_pause,
  input  logic [2:0] preset_a,
  input  logic [2:0] preset_b,
  input  logic       zero_a,
  input  logic       zero_b,
  output logic       load,
  output logic       tick_a,
  output logic       tick_b,
  output logic       jugador,
  output logic [2:0] preset_a_q,
  output logic [2:0] preset_b_q,
  output logic       flag_a,
  output logic       flag_b,
  output logic [2:0] state_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int LW = $clog2(LOCKOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN_A   = 3'd1,
    S_RUN_B   = 3'd2,
    S_PAUSE_A = 3'd3,
    S_PAUSE_B = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_presc;
  logic [LW-1:0]   r_lock;
  logic [3:0]      r_sync1, r_sync2, r_sync3;
  logic            r_load, r_tick_a, r_tick_b, r_jug, r_flag_a, r_flag_b;
  logic [2:0]      r_pa_q, r_pb_q;

  logic [3:0]      w_raw, w_evt;
  logic            w_start, w_a, w_b, w_pause;
  logic            w_run_b, w_zero_cur, w_move_cur, w_term;

  // Button vector order: {pause, b, a, start}
  assign w_raw   = {btn_pause, btn_b, btn_a, btn_start};
  assign w_evt   = (r_lock == '0) ? (r_sync2 & ~r_sync3) : 4'b0000;
  assign w_start = w_evt[0];
  assign w_a     = w_evt[1];
  assign w_b     = w_evt[2];
  assign w_pause = w_evt[3];

  assign w_run_b    = (r_state == S_RUN_B);
  assign w_zero_cur = w_run_b ? zero_b : zero_a;
  assign w_move_cur = w_run_b ? w_b : w_a;
  assign w_term     = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_lock   <= '0;
      r_load   <= 1'b1;
      r_tick_a <= 1'b0;
      r_tick_b <= 1'b0;
      r_jug    <= 1'b0;
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
      r_pa_q   <= '0;
      r_pb_q   <= '0;
    end else begin
      r_sync1  <= w_raw;
      r_sync2  <= r_sync1;
      r_sync3  <= r_sync2;
      r_tick_a <= 1'b0;
      r_tick_b <= 1'b0;
      if (r_lock != '0) r_lock <= r_lock - LW'(1);

      case (r_state)
        S_IDLE: begin
          r_load <= 1'b1;
          r_pa_q <= preset_a;
          r_pb_q <= preset_b;
          if (w_start) begin
            r_state <= S_RUN_A;
            r_load  <= 1'b0;
            r_presc <= '0;
            r_jug   <= 1'b0;
            r_lock  <= LW'(LOCKOUT);
          end
        end

        S_RUN_A, S_RUN_B: begin
          if (w_zero_cur) begin
            // Flag fall beats every button; the running player's counter is frozen.
            r_state <= S_TIMEOUT;
            if (w_run_b) r_flag_b <= 1'b1;
            else         r_flag_a <= 1'b1;
          end else begin
            if (w_term) begin
              r_presc <= '0;
              if (w_run_b) r_tick_b <= 1'b1;
              else         r_tick_a <= 1'b1;
            end else begin
              r_presc <= r_presc + PW'(1);
            end
            // Pause keeps the partial second; a move discards it.
            if (w_pause) begin
              r_state <= w_run_b ? S_PAUSE_B : S_PAUSE_A;
              if (!w_term) r_presc <= r_presc;
              r_lock  <= LW'(LOCKOUT);
            end else if (w_move_cur) begin
              r_state <= w_run_b ? S_RUN_A : S_RUN_B;
              r_jug   <= ~w_run_b;
              r_presc <= '0;
              r_lock  <= LW'(LOCKOUT);
            end
          end
        end

        S_PAUSE_A, S_PAUSE_B: begin
          if (w_pause) begin
            r_state <= (r_state == S_PAUSE_B) ? S_RUN_B : S_RUN_A;
            r_lock  <= LW'(LOCKOUT);
          end else if (w_start) begin
            r_state <= S_IDLE;
            r_load  <= 1'b1;
            r_jug   <= 1'b0;
            r_lock  <= LW'(LOCKOUT);
          end
        end

        S_TIMEOUT: begin
          if (w_start) begin
            r_state  <= S_IDLE;
            r_load   <= 1'b1;
            r_jug    <= 1'b0;
            r_flag_a <= 1'b0;
            r_flag_b <= 1'b0;
            r_lock   <= LW'(LOCKOUT);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_load  <= 1'b1;
        end
      endcase
    end
  end

  assign load       = r_load;
  assign tick_a     = r_tick_a;
  assign tick_b     = r_tick_b;
  assign jugador    = r_jug;
  assign preset_a_q = r_pa_q;
  assign preset_b_q = r_pb_q;
  assign flag_a     = r_flag_a;
  assign flag_b     = r_flag_b;
  assign state_o    = r_state;

endmodule
